vc_buffer_bank5: RTL and testbench

Five-VC input buffer bank for one router input port. It stores incoming flits per virtual channel and presents the head timestamp of each VC to the downstream 5-to-1 oldest-first VC arbiter. It takes the arbiter's winning VC index as a dequeue request and returns the dequeued flit one cycle later. It is the supply and consume side of the arbiter interface: `time_out_0..4` feed the arbiter's `time_in_0..4`, and the arbiter's `winner_vc_out` drives `deq_vc_in`.

---
 rtl/vc_buffer_bank5.sv | 186 ++++++++++++++++++
 tb/tb_vc_buffer_bank5.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_buffer_bank5.sv
// Five-VC input buffer bank: per-VC circular FIFOs presenting head timestamps to an oldest-first arbiter.
// Optional VC_CREDIT_EN adds a registered credit-return pulse aligned with deq_valid_out.

`ifndef TIME_WIDTH
`define TIME_WIDTH 16
`endif
`ifndef VC_INDEX_WIDTH
`define VC_INDEX_WIDTH 3
`endif

module vc_buffer_bank5 #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enq_valid_in,
    input  logic [`VC_INDEX_WIDTH-1:0]  enq_vc_in,
    input  logic [DATA_WIDTH-1:0]       enq_data_in,
    input  logic [`TIME_WIDTH-1:0]      enq_time_in,
    input  logic                        deq_en_in,
    input  logic [`VC_INDEX_WIDTH-1:0]  deq_vc_in,
    output logic [`TIME_WIDTH-1:0]      time_out_0,
    output logic [`TIME_WIDTH-1:0]      time_out_1,
    output logic [`TIME_WIDTH-1:0]      time_out_2,
    output logic [`TIME_WIDTH-1:0]      time_out_3,
    output logic [`TIME_WIDTH-1:0]      time_out_4,
    output logic [4:0]                  head_valid_out,
    output logic                        deq_valid_out,
    output logic [DATA_WIDTH-1:0]       deq_data_out,
    output logic [`TIME_WIDTH-1:0]      deq_time_out,
    output logic                        err_overflow_out,
    output logic                        err_underflow_out
`ifdef VC_CREDIT_EN
    ,
    output logic                        credit_valid_out,
    output logic [`VC_INDEX_WIDTH-1:0]  credit_vc_out
`endif
);

    localparam int unsigned NUM_VC = 5;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TIME_W = `TIME_WIDTH;
    localparam int unsigned VC_W   = `VC_INDEX_WIDTH;

    logic [PTR_W-1:0]      rd_ptr_q [NUM_VC];
    logic [PTR_W-1:0]      rd_ptr_d [NUM_VC];
    logic [PTR_W-1:0]      wr_ptr_q [NUM_VC];
    logic [PTR_W-1:0]      wr_ptr_d [NUM_VC];
    logic [CNT_W-1:0]      cnt_q    [NUM_VC];
    logic [CNT_W-1:0]      cnt_d    [NUM_VC];
    logic [DATA_WIDTH-1:0] data_mem_q [NUM_VC][DEPTH];
    logic [TIME_W-1:0]     time_mem_q [NUM_VC][DEPTH];

    logic [NUM_VC-1:0]     wr_en_c;
    logic [NUM_VC-1:0]     rd_en_c;
    logic [NUM_VC-1:0]     full_c;
    logic [TIME_W-1:0]     head_time_c [NUM_VC];

    logic                  deq_valid_q, deq_valid_d;
    logic [DATA_WIDTH-1:0] deq_data_q,  deq_data_d;
    logic [TIME_W-1:0]     deq_time_q,  deq_time_d;
    logic                  err_ovf_q,   err_ovf_d;
    logic                  err_udf_q,   err_udf_d;
    logic [VC_W-1:0]       deq_vc_d;

    // Per-VC accept decisions; a full VC may accept only when it is also dequeued this cycle.
    always_comb begin
        wr_en_c     = '0;
        rd_en_c     = '0;
        full_c      = '0;
        deq_valid_d = 1'b0;
        deq_data_d  = deq_data_q;
        deq_time_d  = deq_time_q;
        deq_vc_d    = '0;
        err_ovf_d   = err_ovf_q;
        err_udf_d   = err_udf_q;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            rd_ptr_d[v] = rd_ptr_q[v];
            wr_ptr_d[v] = wr_ptr_q[v];
            cnt_d[v]    = cnt_q[v];
            full_c[v]   = (cnt_q[v] == CNT_W'(DEPTH));
            rd_en_c[v]  = deq_en_in && (deq_vc_in == VC_W'(v)) && (cnt_q[v] != '0);
            wr_en_c[v]  = enq_valid_in && (enq_vc_in == VC_W'(v)) && (!full_c[v] || rd_en_c[v]);
            if (rd_en_c[v]) begin
                rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(1);
                deq_valid_d = 1'b1;
                deq_data_d  = data_mem_q[v][rd_ptr_q[v]];
                deq_time_d  = time_mem_q[v][rd_ptr_q[v]];
                deq_vc_d    = VC_W'(v);
            end
            if (wr_en_c[v]) begin
                wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(1);
            end
            case ({wr_en_c[v], rd_en_c[v]})
                2'b10:   cnt_d[v] = cnt_q[v] + CNT_W'(1);
                2'b01:   cnt_d[v] = cnt_q[v] - CNT_W'(1);
                default: cnt_d[v] = cnt_q[v];
            endcase
        end
        // Dropped writes cover both full VCs and out-of-range VC indices.
        if (enq_valid_in && (wr_en_c == '0)) begin
            err_ovf_d = 1'b1;
        end
        if (deq_en_in && !deq_valid_d) begin
            err_udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
            deq_valid_q <= 1'b0;
            deq_data_q  <= '0;
            deq_time_q  <= '0;
            err_ovf_q   <= 1'b0;
            err_udf_q   <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                rd_ptr_q[v] <= rd_ptr_d[v];
                wr_ptr_q[v] <= wr_ptr_d[v];
                cnt_q[v]    <= cnt_d[v];
            end
            deq_valid_q <= deq_valid_d;
            deq_data_q  <= deq_data_d;
            deq_time_q  <= deq_time_d;
            err_ovf_q   <= err_ovf_d;
            err_udf_q   <= err_udf_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            if (wr_en_c[v]) begin
                data_mem_q[v][wr_ptr_q[v]] <= enq_data_in;
                time_mem_q[v][wr_ptr_q[v]] <= enq_time_in;
            end
        end
    end

    always_comb begin
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            head_time_c[v] = (cnt_q[v] != '0) ? time_mem_q[v][rd_ptr_q[v]] : '1;
            head_valid_out[v] = (cnt_q[v] != '0);
        end
    end

    assign time_out_0        = head_time_c[0];
    assign time_out_1        = head_time_c[1];
    assign time_out_2        = head_time_c[2];
    assign time_out_3        = head_time_c[3];
    assign time_out_4        = head_time_c[4];
    assign deq_valid_out     = deq_valid_q;
    assign deq_data_out      = deq_data_q;
    assign deq_time_out      = deq_time_q;
    assign err_overflow_out  = err_ovf_q;
    assign err_underflow_out = err_udf_q;

`ifdef VC_CREDIT_EN
    logic            credit_valid_q;
    logic [VC_W-1:0] credit_vc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
        end else begin
            credit_valid_q <= deq_valid_d;
            credit_vc_q    <= deq_valid_d ? deq_vc_d : credit_vc_q;
        end
    end

    assign credit_valid_out = credit_valid_q;
    assign credit_vc_out    = credit_vc_q;
`else
    logic unused_deq_vc;
    assign unused_deq_vc = ^deq_vc_d;
`endif

endmodule

// File: tb/tb_vc_buffer_bank5.sv
// Scoreboard bench for vc_buffer_bank5: per-VC queue model, expected dequeues checked by a negedge monitor.

`ifndef TIME_WIDTH
`define TIME_WIDTH 16
`endif
`ifndef VC_INDEX_WIDTH
`define VC_INDEX_WIDTH 3
`endif

module tb_vc_buffer_bank5;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TW    = `TIME_WIDTH;
    localparam int unsigned VW    = `VC_INDEX_WIDTH;

    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } flit_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        int unsigned   vc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enq_valid;
    logic [VW-1:0] enq_vc;
    logic [DW-1:0] enq_data;
    logic [TW-1:0] enq_time;
    logic          deq_en;
    logic [VW-1:0] deq_vc;
    logic [TW-1:0] tout [5];
    logic [4:0]    head_valid;
    logic          deq_valid;
    logic [DW-1:0] deq_data;
    logic [TW-1:0] deq_time;
    logic          err_ovf;
    logic          err_udf;
`ifdef VC_CREDIT_EN
    logic          credit_valid;
    logic [VW-1:0] credit_vc;
`endif

    int errors = 0;
    int checks = 0;

    flit_t vcq [5][$];
    exp_t  exp_q [$];
    bit    m_ovf = 1'b0;
    bit    m_udf = 1'b0;

    always #5 clk = ~clk;

    vc_buffer_bank5 #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enq_valid_in      (enq_valid),
        .enq_vc_in         (enq_vc),
        .enq_data_in       (enq_data),
        .enq_time_in       (enq_time),
        .deq_en_in         (deq_en),
        .deq_vc_in         (deq_vc),
        .time_out_0        (tout[0]),
        .time_out_1        (tout[1]),
        .time_out_2        (tout[2]),
        .time_out_3        (tout[3]),
        .time_out_4        (tout[4]),
        .head_valid_out    (head_valid),
        .deq_valid_out     (deq_valid),
        .deq_data_out      (deq_data),
        .deq_time_out      (deq_time),
        .err_overflow_out  (err_ovf),
        .err_underflow_out (err_udf)
`ifdef VC_CREDIT_EN
        ,
        .credit_valid_out  (credit_valid),
        .credit_vc_out     (credit_vc)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO rules applied to the pre-edge queue contents.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < 5; v++) vcq[v].delete();
            exp_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            int unsigned dv;
            int unsigned ev;
            bit dok;
            bit eok;
            flit_t f;
            dv  = int'(deq_vc);
            ev  = int'(enq_vc);
            dok = 1'b0;
            eok = 1'b0;
            if (deq_en && dv < 5) begin
                if (vcq[dv].size() > 0) dok = 1'b1;
            end
            if (enq_valid && ev < 5) begin
                if (vcq[ev].size() < DEPTH || (dok && dv == ev)) eok = 1'b1;
            end
            if (dok) begin
                f = vcq[dv].pop_front();
                exp_q.push_back('{d: f.d, t: f.t, vc: dv});
            end
            if (eok) vcq[ev].push_back('{d: enq_data, t: enq_time});
            if (enq_valid && !eok) m_ovf = 1'b1;
            if (deq_en && !dok) m_udf = 1'b1;
        end
    end

    // Monitor: head/flag state every cycle, dequeue results popped from the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        for (int v = 0; v < 5; v++) begin
            chk($sformatf("head_valid[%0d]", v), 64'(head_valid[v]), 64'(vcq[v].size() != 0));
            if (vcq[v].size() != 0) chk($sformatf("time_out_%0d", v), 64'(tout[v]), 64'(vcq[v][0].t));
            else                    chk($sformatf("time_out_%0d", v), 64'(tout[v]), 64'({TW{1'b1}}));
        end
        chk("err_overflow", 64'(err_ovf), 64'(m_ovf));
        chk("err_underflow", 64'(err_udf), 64'(m_udf));
        if (deq_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_deq_valid", 64'(deq_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("deq_data", deq_data, e.d);
                chk("deq_time", 64'(deq_time), 64'(e.t));
`ifdef VC_CREDIT_EN
                chk("credit_valid", 64'(credit_valid), 64'(1));
                chk("credit_vc", 64'(credit_vc), 64'(e.vc));
`endif
            end
        end else begin
            chk("missing_deq_valid", 64'(exp_q.size()), 64'(0));
`ifdef VC_CREDIT_EN
            chk("credit_idle", 64'(credit_valid), 64'(0));
`endif
        end
    end

    task automatic cyc(input bit ev, input int evc, input logic [DW-1:0] ed, input logic [TW-1:0] et,
                       input bit de, input int dvc);
        @(negedge clk);
        enq_valid = ev;
        enq_vc    = VW'(evc);
        enq_data  = ed;
        enq_time  = et;
        deq_en    = de;
        deq_vc    = VW'(dvc);
    endtask

    task automatic idle();
        cyc(1'b0, 0, '0, '0, 1'b0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        enq_valid = 1'b0;
        deq_en    = 1'b0;
        @(negedge clk);
        chk("rst_deq_valid", 64'(deq_valid), 64'(0));
        chk("rst_deq_data", deq_data, 64'(0));
        chk("rst_deq_time", 64'(deq_time), 64'(0));
        chk("rst_head_valid", 64'(head_valid), 64'(0));
        chk("rst_time_out_4", 64'(tout[4]), 64'({TW{1'b1}}));
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        enq_valid = 1'b0;
        enq_vc    = '0;
        enq_data  = '0;
        enq_time  = '0;
        deq_en    = 1'b0;
        deq_vc    = '0;
        #1 rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_deq_data", deq_data, 64'(0));
        chk("rst_head_valid", 64'(head_valid), 64'(0));
        #2 rst_n = 1'b1;

        // Single enqueue/dequeue on VC2.
        cyc(1, 2, 64'hA5, 16'd7, 0, 0);
        idle();
        chk("single_time_out_2", 64'(tout[2]), 64'd7);
        cyc(0, 0, '0, '0, 1, 2);
        idle();
        chk("single_deq_data", deq_data, 64'hA5);

        // Fill VC0, overflow with a fifth write, drain in order.
        for (int i = 0; i < DEPTH + 1; i++) cyc(1, 0, 64'(100 + i), TW'(10 + i), 0, 0);
        idle();
        chk("fill_overflow", 64'(err_ovf), 64'(1));
        // Full VC0 with simultaneous enq and deq.
        cyc(1, 0, 64'h55, TW'(50), 1, 0);
        idle();
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, '0, '0, 1, 0);
        idle();
        idle();

        // Underflow: empty VC3, then enq+deq on empty VC4.
        do_reset();
        cyc(0, 0, '0, '0, 1, 3);
        cyc(1, 4, 64'hBEEF, TW'(3), 1, 4);
        cyc(0, 0, '0, '0, 1, 6);
        idle();
        chk("underflow_flag", 64'(err_udf), 64'(1));
        chk("vc4_holds_one", 64'(head_valid), 64'b10000);

        // Streaming enq/deq on VC1 across several pointer wraps.
        cyc(1, 1, 64'h1000, TW'(1000), 0, 0);
        for (int i = 0; i < 3 * DEPTH; i++) cyc(1, 1, 64'(64'h2000 + i), TW'(2000 + i), 1, 1);
        cyc(0, 0, '0, '0, 1, 1);
        idle();

        // Mid-operation reset with a dequeue in flight.
        cyc(1, 2, 64'h77, TW'(9), 0, 0);
        cyc(0, 0, '0, '0, 1, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        enq_valid = 1'b0;
        deq_en    = 1'b0;
        @(negedge clk);
        chk("midrst_deq_valid", 64'(deq_valid), 64'(0));
        #2 rst_n = 1'b1;

        // Random traffic, biased toward in-range VCs.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            cyc(($urandom_range(0, 99) < 60), int'($urandom_range(0, 5)),
                {$urandom, $urandom}, TW'($urandom),
                ($urandom_range(0, 99) < 55), int'($urandom_range(0, 5)));
        end
        idle();
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
